// File: rtl/dmem_pkg.sv
// Shared types for the data memory with sweep engine: FSM states and sweep opcodes.
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_SCAN = 1'b1;

endpackage

// File: rtl/dmem_ram.sv
// Inferred single-port synchronous RAM with selectable read-during-write behaviour.
module dmem_ram #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int RDW_NEW = 0
) (
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if ((RDW_NEW != 0) && we) begin
            q <= wdata;
        end else begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_sweep.sv
// Datapath data memory with a sweep engine that fills every cell or streams every cell out.
module data_memory_sweep
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int RDW_NEW = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] W_data,
    input  logic              D_wr,
    output logic [DATA_W-1:0] R_data,
    input  logic              Cmd_start,
    input  logic              Cmd_op,
    input  logic [DATA_W-1:0] Fill_data,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Scan_addr,
    output logic [DATA_W-1:0] Scan_data,
    output logic              Scan_valid
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] fill_q;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    logic              host_rd;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] scan_hold;
    logic              done_q;

    dmem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RDW_NEW(RDW_NEW)
    ) u_ram (
        .Clk  (Clk),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .we   (ram_we),
        .q    (ram_q)
    );

    always_comb begin
        state_nx  = state;
        ram_addr  = Addr;
        ram_wdata = W_data;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                ram_we = D_wr;
                if (Cmd_start) begin
                    state_nx = (Cmd_op == OP_SCAN) ? SCAN : FILL;
                end
            end
            FILL: begin
                ram_addr  = cnt;
                ram_wdata = fill_q;
                ram_we    = 1'b1;
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            SCAN: begin
                ram_addr = cnt;
                if (cnt == LAST) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Counter saturates on all-ones so the last access is never repeated or wrapped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt    <= '0;
            fill_q <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (Cmd_start) begin
                fill_q <= Fill_data;
            end
        end else if (((state == FILL) || (state == SCAN)) && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            host_rd    <= 1'b0;
            r_hold     <= '0;
            Scan_valid <= 1'b0;
            Scan_addr  <= '0;
            scan_hold  <= '0;
            done_q     <= 1'b0;
        end else begin
            host_rd    <= (state == IDLE);
            r_hold     <= R_data;
            Scan_valid <= (state == SCAN);
            if (state == SCAN) begin
                Scan_addr <= cnt;
            end
            scan_hold  <= Scan_data;
            done_q     <= (state == DONE);
        end
    end

    // The RAM output register is shared; the hold registers keep each consumer's
    // last word while the other side owns the array, and give clean reset values.
    assign R_data    = host_rd ? ram_q : r_hold;
    assign Scan_data = Scan_valid ? ram_q : scan_hold;
    assign Busy      = (state != IDLE);
    assign Done      = done_q;

endmodule

// File: tb/tb_data_memory_sweep.sv
// Self-checking bench: two instances (old/new read-during-write) against an array model.
module tb_data_memory_sweep;
    import dmem_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 2**AW;

    logic          Clk;
    logic          Reset_n;
    logic [AW-1:0] Addr;
    logic [DW-1:0] W_data;
    logic          D_wr;
    logic          Cmd_start;
    logic          Cmd_op;
    logic [DW-1:0] Fill_data;

    logic [DW-1:0] r_data    [2];
    logic [AW-1:0] scan_addr [2];
    logic [DW-1:0] scan_data [2];
    logic [1:0]    busy;
    logic [1:0]    done;
    logic [1:0]    scan_valid;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_memory_sweep #(
            .DATA_W (DW),
            .ADDR_W (AW),
            .RDW_NEW(g)
        ) u_dut (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .Addr      (Addr),
            .W_data    (W_data),
            .D_wr      (D_wr),
            .R_data    (r_data[g]),
            .Cmd_start (Cmd_start),
            .Cmd_op    (Cmd_op),
            .Fill_data (Fill_data),
            .Busy      (busy[g]),
            .Done      (done[g]),
            .Scan_addr (scan_addr[g]),
            .Scan_data (scan_data[g]),
            .Scan_valid(scan_valid[g])
        );
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        Addr = a; W_data = d; D_wr = 1'b1;
        tick();
        D_wr = 1'b0;
        mem[a] = d;
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input string tag);
        Addr = a; D_wr = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) check($sformatf("%s[%0d]", tag, i), 32'(r_data[i]), 32'(mem[a]));
    endtask

    task automatic run_sweep(input logic op, input logic [DW-1:0] fill, input bit inject);
        int done_k [2];
        int done_n [2];
        int beats  [2];
        int busy_n [2];
        logic [DW-1:0] r_exp;
        for (int i = 0; i < 2; i++) begin
            done_k[i] = -1; done_n[i] = 0; beats[i] = 0; busy_n[i] = 0;
        end
        Cmd_start = 1'b1; Cmd_op = op; Fill_data = fill; D_wr = 1'b0;
        tick();
        Cmd_start = 1'b0;
        r_exp = mem[Addr];
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy_start[%0d]", i), 32'(busy[i]), 32'd1);
            check($sformatf("rd_at_start[%0d]", i), 32'(r_data[i]), 32'(r_exp));
        end
        for (int k = 1; k <= DEPTH + 6; k++) begin
            if (inject && k == 10) begin
                D_wr = 1'b1; Addr = 8'h05; W_data = 16'h1234; Cmd_start = 1'b1; Cmd_op = OP_SCAN;
            end
            if (inject && k == 11) begin
                D_wr = 1'b0; Cmd_start = 1'b0;
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) busy_n[i]++;
                if (done[i]) begin
                    done_n[i]++;
                    done_k[i] = k;
                end
                if (done[i] && scan_valid[i]) check($sformatf("valid_and_done[%0d]", i), 32'd1, 32'd0);
                if (scan_valid[i]) begin
                    check($sformatf("scan_cycle[%0d]", i), 32'(k), 32'(beats[i] + 1));
                    check($sformatf("scan_addr[%0d]", i), 32'(scan_addr[i]), 32'(beats[i]));
                    check($sformatf("scan_data[%0d]", i), 32'(scan_data[i]), 32'(mem[beats[i] % DEPTH]));
                    beats[i]++;
                end
                if (k == DEPTH) check($sformatf("rd_hold[%0d]", i), 32'(r_data[i]), 32'(r_exp));
            end
        end
        if (op == OP_FILL) begin
            for (int a = 0; a < DEPTH; a++) mem[a] = fill;
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("done_count[%0d]", i), 32'(done_n[i]), 32'd1);
            check($sformatf("done_cycle[%0d]", i), 32'(done_k[i]),
                  32'((op == OP_FILL) ? DEPTH + 1 : DEPTH + 2));
            check($sformatf("scan_beats[%0d]", i), 32'(beats[i]), 32'((op == OP_SCAN) ? DEPTH : 0));
            check($sformatf("busy_cycles[%0d]", i), 32'(busy_n[i]),
                  32'((op == OP_FILL) ? DEPTH : DEPTH + 1));
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] old;
        bit            we;

        Reset_n = 1'b0; Addr = '0; W_data = '0; D_wr = 1'b0;
        Cmd_start = 1'b0; Cmd_op = OP_FILL; Fill_data = '0;
        #3;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_rdata[%0d]", i), 32'(r_data[i]), 32'd0);
            check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'd0);
            check($sformatf("rst_valid[%0d]", i), 32'(scan_valid[i]), 32'd0);
            check($sformatf("rst_saddr[%0d]", i), 32'(scan_addr[i]), 32'd0);
            check($sformatf("rst_sdata[%0d]", i), 32'(scan_data[i]), 32'd0);
        end
        tick();
        Reset_n = 1'b1;
        tick();

        run_sweep(OP_FILL, 16'h0000, 1'b0);
        host_write(8'h12, 16'hBEEF);
        read_chk(8'h12, "rd_beef");
        read_chk(8'h13, "rd_unwritten");

        run_sweep(OP_FILL, 16'hA5A5, 1'b0);
        read_chk(8'h00, "fill_00");
        read_chk(8'h7F, "fill_7f");
        read_chk(8'hFF, "fill_ff");

        for (int k = 0; k < DEPTH; k++) host_write(AW'(k), {8'h00, 8'(k)});
        run_sweep(OP_SCAN, '0, 1'b0);

        run_sweep(OP_FILL, 16'h3C3C, 1'b1);
        read_chk(8'h05, "fill_ignores_host");

        // Abort a fill of 16'hFFFF over zeros once the counter reaches 8'h40.
        run_sweep(OP_FILL, 16'h0000, 1'b0);
        Cmd_start = 1'b1; Cmd_op = OP_FILL; Fill_data = 16'hFFFF;
        tick();
        Cmd_start = 1'b0;
        repeat (8'h40) tick();
        #1;
        Reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_busy[%0d]", i), 32'(busy[i]), 32'd0);
            check($sformatf("abort_done[%0d]", i), 32'(done[i]), 32'd0);
            check($sformatf("abort_valid[%0d]", i), 32'(scan_valid[i]), 32'd0);
            check($sformatf("abort_rdata[%0d]", i), 32'(r_data[i]), 32'd0);
            check($sformatf("abort_sdata[%0d]", i), 32'(scan_data[i]), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int i = 0; i < 2; i++) check($sformatf("abort_no_done[%0d]", i), 32'(done[i]), 32'd0);
        end
        Reset_n = 1'b1;
        for (int k = 0; k < 8'h40; k++) mem[k] = 16'hFFFF;
        tick();
        for (int i = 0; i < 2; i++) check($sformatf("abort_idle_done[%0d]", i), 32'(done[i]), 32'd0);
        read_chk(8'h00, "abort_00");
        read_chk(8'h3F, "abort_3f");
        read_chk(8'h40, "abort_40");
        read_chk(8'h41, "abort_41");
        run_sweep(OP_SCAN, '0, 1'b0);

        host_write(8'h20, 16'h1111);
        Addr = 8'h20; W_data = 16'h5555; D_wr = 1'b1;
        tick();
        D_wr = 1'b0;
        check("rdw_old[0]", 32'(r_data[0]), 32'h1111);
        check("rdw_new[1]", 32'(r_data[1]), 32'h5555);
        mem[8'h20] = 16'h5555;
        read_chk(8'h20, "rdw_after");

        // Random host traffic on a narrow window so same-address collisions are frequent.
        for (int n = 0; n < 300; n++) begin
            a  = AW'($urandom_range(0, 15));
            d  = DW'($urandom);
            we = 1'($urandom_range(0, 1));
            Addr = a; W_data = d; D_wr = we;
            tick();
            old = mem[a];
            check("rand_rd[0]", 32'(r_data[0]), 32'(old));
            check("rand_rd[1]", 32'(r_data[1]), 32'(we ? d : old));
            if (we) mem[a] = d;
        end
        D_wr = 1'b0;

        run_sweep(OP_SCAN, '0, 1'b0);
        run_sweep(OP_FILL, DW'($urandom), 1'b0);
        run_sweep(OP_SCAN, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
